// File: rtl/pe_mac_acc_param.sv
// pe_mac_acc_param
//   Processing element for one output-channel lane. Each accepted beat forms
//   an N_CELL-wide signed dot product; beats of a group (1..8 beats) are summed
//   at full ACC_BIT precision on top of the group bias. The finished group is
//   arithmetically right-shifted by BASE_SHIFT+bound_level, saturated to
//   OUT_BIT signed, optionally ReLU'd, and presented with a valid/ready handshake.
//
//   Ports
//     clk          clock, rising edge
//     reset        asynchronous active-low reset
//     clr          synchronous flush of partial group, stage 1 and output
//     in, weight   N_CELL packed signed CELL_BIT elements (cell k at [k*CELL_BIT +: CELL_BIT])
//     bias         signed group bias, sampled on the first beat
//     step         group length minus one, sampled on the first beat
//     bound_level  extra right shift, sampled on the first beat
//     relu_en      clamp negative results to zero, sampled on the first beat
//     in_valid     beat present
//     in_ready     beat accepted when in_valid & in_ready
//     out          signed requantised result
//     out_valid    result present, held until out_ready
//     out_ready    downstream accepts
//     out_sat      result was clipped by saturation
module pe_mac_acc_param #(
  parameter int CELL_BIT   = 8,
  parameter int N_CELL     = 9,
  parameter int BIAS_BIT   = 16,
  parameter int ACC_BIT    = 24,
  parameter int OUT_BIT    = 8,
  parameter int BASE_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic [CELL_BIT*N_CELL-1:0] in,
  input  logic [CELL_BIT*N_CELL-1:0] weight,
  input  logic [BIAS_BIT-1:0]        bias,
  input  logic [2:0]                 step,
  input  logic [2:0]                 bound_level,
  input  logic                       relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OUT_BIT-1:0]         out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sat
);

  localparam logic signed [ACC_BIT-1:0] SAT_MAX = ACC_BIT'((1 << (OUT_BIT-1)) - 1);
  localparam logic signed [ACC_BIT-1:0] SAT_MIN = ~SAT_MAX;

  logic                       advance, accept, first, last;
  logic [2:0]                 cnt, step_l, bound_l, step_g, bound_g;
  logic [BIAS_BIT-1:0]        bias_l, bias_g;
  logic                       relu_l, relu_g;
  logic signed [ACC_BIT-1:0]  dot;

  logic                       s1_valid, s1_first, s1_last, s1_relu;
  logic signed [ACC_BIT-1:0]  s1_sum;
  logic [BIAS_BIT-1:0]        s1_bias;
  logic [2:0]                 s1_bound;

  logic signed [ACC_BIT-1:0]  acc, acc_n, bias_ext, shifted;
  logic [4:0]                 shamt;
  logic                       clip;
  logic [OUT_BIT-1:0]         sat_val, q;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance & ~clr;
  assign first    = (cnt == 3'd0);

  // Group controls come straight from the ports on the first beat and from
  // the latched copies afterwards, so mid-group port changes are ignored.
  assign step_g  = first ? step        : step_l;
  assign bias_g  = first ? bias        : bias_l;
  assign bound_g = first ? bound_level : bound_l;
  assign relu_g  = first ? relu_en     : relu_l;
  assign last    = (cnt == step_g);

  always_comb begin
    logic signed [CELL_BIT-1:0]   a, b;
    logic signed [2*CELL_BIT-1:0] prod;
    logic signed [ACC_BIT-1:0]    prod_ext;
    a        = '0;
    b        = '0;
    prod     = '0;
    prod_ext = '0;
    dot      = '0;
    for (int unsigned k = 0; k < N_CELL; k++) begin
      a        = in[k*CELL_BIT +: CELL_BIT];
      b        = weight[k*CELL_BIT +: CELL_BIT];
      prod     = a * b;
      prod_ext = prod;
      dot      = dot + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      step_l  <= '0;
      bias_l  <= '0;
      bound_l <= '0;
      relu_l  <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? 3'd0 : cnt + 3'd1;
      if (first) begin
        step_l  <= step;
        bias_l  <= bias;
        bound_l <= bound_level;
        relu_l  <= relu_en;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_bias  <= '0;
      s1_bound <= '0;
      s1_relu  <= 1'b0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum   <= dot;
        s1_first <= first;
        s1_last  <= last;
        s1_bias  <= bias_g;
        s1_bound <= bound_g;
        s1_relu  <= relu_g;
      end
    end
  end

  always_comb begin
    bias_ext = ACC_BIT'($signed(s1_bias));
    acc_n    = (s1_first ? bias_ext : acc) + s1_sum;
    shamt    = 5'(BASE_SHIFT) + {2'b00, s1_bound};
    shifted  = acc_n >>> shamt;
    clip     = 1'b0;
    sat_val  = shifted[OUT_BIT-1:0];
    if (shifted > SAT_MAX) begin
      clip    = 1'b1;
      sat_val = {1'b0, {(OUT_BIT-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      clip    = 1'b1;
      sat_val = {1'b1, {(OUT_BIT-1){1'b0}}};
    end
    q = (s1_relu && sat_val[OUT_BIT-1]) ? '0 : sat_val;
  end

  // A consume and a new result in the same cycle simply reload out with
  // out_valid kept high; without a new result, advancing drops out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      if (s1_valid) acc <= acc_n;
      if (s1_valid && s1_last) begin
        out       <= q;
        out_sat   <= clip;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_acc_param.sv
module tb_pe_mac_acc_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic [71:0] din, wt;
  logic [15:0] bias;
  logic [2:0]  step, bound_level;
  logic        relu_en, in_valid, in_ready;
  logic [7:0]  out;
  logic        out_valid, out_ready, out_sat;

  int total = 0;
  int bad   = 0;

  pe_mac_acc_param #(
    .CELL_BIT(8), .N_CELL(9), .BIAS_BIT(16), .ACC_BIT(24), .OUT_BIT(8), .BASE_SHIFT(4)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .in(din), .weight(wt), .bias(bias),
    .step(step), .bound_level(bound_level), .relu_en(relu_en), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [7:0] v, input logic [7:0] w, input logic [15:0] b,
                          input logic [2:0] s, input logic [2:0] bd, input logic r);
    din = {9{v}};
    wt = {9{w}};
    bias = b;
    step = s;
    bound_level = bd;
    relu_en = r;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_beat(8'd0, 8'd0, 16'd0, 3'd0, 3'd0, 1'b0);
    #12;
    total++; if (out !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    cyc();
  endtask

  task automatic test_single_beat();
    idle();
    set_beat(8'd1, 8'd2, 16'd0, 3'd0, 3'd0, 1'b0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", out_valid); end
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
    total++; if (out !== 8'd1) begin bad++; $display("FAIL single_out got=%0d exp=1", out); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL single_sat got=%b exp=0", out_sat); end
  endtask

  task automatic test_multi_beat();
    // bound=0: 3500>>4 = 218 -> saturates to 127
    idle();
    set_beat(8'd10, 8'd10, -16'sd100, 3'd3, 3'd0, 1'b0);
    in_valid = 1'b1;
    cyc();
    bias = 16'd999;
    for (int i = 0; i < 3; i++) cyc();
    in_valid = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL grp_valid got=%b exp=1", out_valid); end
    total++; if (out !== 8'd127) begin bad++; $display("FAIL grp_sat_out got=%0d exp=127", $signed(out)); end
    total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL grp_sat_flag got=%b exp=1", out_sat); end
    // bound=2: 3500>>6 = 54; mid-group control changes must be ignored
    idle();
    set_beat(8'd10, 8'd10, -16'sd100, 3'd3, 3'd2, 1'b0);
    in_valid = 1'b1;
    cyc();
    set_beat(8'd10, 8'd10, 16'd0, 3'd0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
    in_valid = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL grp2_valid got=%b exp=1", out_valid); end
    total++; if (out !== 8'd54) begin bad++; $display("FAIL grp2_out got=%0d exp=54", $signed(out)); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL grp2_sat got=%b exp=0", out_sat); end
  endtask

  task automatic test_relu();
    idle();
    set_beat(-8'sd8, 8'd16, 16'd0, 3'd0, 3'd0, 1'b0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    total++; if (out !== 8'hB8) begin bad++; $display("FAIL neg_out got=%0d exp=-72", $signed(out)); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL neg_sat got=%b exp=0", out_sat); end
    idle();
    set_beat(-8'sd8, 8'd16, 16'd0, 3'd0, 3'd0, 1'b1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    total++; if (out !== 8'd0) begin bad++; $display("FAIL relu_out got=%0d exp=0", $signed(out)); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL relu_valid got=%b exp=1", out_valid); end
  endtask

  task automatic test_back_to_back();
    idle();
    out_ready = 1'b0;
    set_beat(8'd1, 8'd2, 16'd0, 3'd0, 3'd0, 1'b0);
    in_valid = 1'b1;
    cyc();
    set_beat(8'd10, 8'd10, 16'd0, 3'd0, 3'd0, 1'b0);
    cyc();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (out_valid !== 1'b1 || out !== 8'd1) begin
        bad++; $display("FAIL stall_hold got=%0d/%b exp=1/1", out, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL resume_in_ready got=%b exp=1", in_ready); end
    cyc();
    total++;
    if (out_valid !== 1'b1 || out !== 8'd56) begin
      bad++; $display("FAIL second_result got=%0d/%b exp=56/1", out, out_valid);
    end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_dup got=%b exp=0", out_valid); end
    total++; if (out !== 8'd56) begin bad++; $display("FAIL out_kept got=%0d exp=56", out); end
  endtask

  task automatic test_reset_mid_group();
    idle();
    set_beat(8'd10, 8'd10, -16'sd100, 3'd3, 3'd0, 1'b0);
    in_valid = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    total++; if (out !== 8'd0) begin bad++; $display("FAIL rst_mid_out got=%0d exp=0", out); end
    #1;
    reset = 1'b1;
    set_beat(8'd1, 8'd2, 16'd0, 3'd0, 3'd0, 1'b0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    total++;
    if (out_valid !== 1'b1 || out !== 8'd1) begin
      bad++; $display("FAIL rst_fresh got=%0d/%b exp=1/1", $signed(out), out_valid);
    end
  endtask

  task automatic test_clr();
    idle();
    set_beat(8'd1, 8'd2, 16'd0, 3'd0, 3'd0, 1'b0);
    in_valid = 1'b1;
    cyc();
    set_beat(8'd10, 8'd10, 16'd500, 3'd2, 3'd0, 1'b0);
    cyc();
    total++;
    if (out_valid !== 1'b1 || out !== 8'd1) begin
      bad++; $display("FAIL clr_pending got=%0d/%b exp=1/1", out, out_valid);
    end
    out_ready = 1'b0;
    clr = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL clr_sat got=%b exp=0", out_sat); end
    clr = 1'b0;
    out_ready = 1'b1;
    set_beat(8'd1, 8'd2, 16'd14, 3'd0, 3'd0, 1'b0);
    cyc();
    in_valid = 1'b0;
    cyc();
    total++;
    if (out_valid !== 1'b1 || out !== 8'd2) begin
      bad++; $display("FAIL clr_next got=%0d/%b exp=2/1", $signed(out), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_relu();
    test_back_to_back();
    test_reset_mid_group();
    test_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
